// File: rtl/chaos_keystream_xor.sv
// Chaos-keyed pixel stream cipher: quantises generator samples into 32-bit key words,
// buffers them in a small FIFO and encrypts a length-programmed pixel frame with CBC-style chaining.
module chaos_keystream_xor #(
    parameter int          TOTAL_BITS = 32,
    parameter int          KEY_LSB    = 16,
    parameter int          KEY_DEPTH  = 4,
    parameter logic [7:0]  IV         = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  chaos_start,
    input  logic [TOTAL_BITS-1:0] x_seq,
    input  logic [TOTAL_BITS-1:0] y_seq,
    input  logic [TOTAL_BITS-1:0] z_seq,
    input  logic [TOTAL_BITS-1:0] w_seq,
    input  logic                  x_ap_valid,
    input  logic                  y_ap_valid,
    input  logic                  z_ap_valid,
    input  logic                  w_ap_valid,
    input  logic                  frame_start,
    input  logic [15:0]           cfg_len,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int AW = (KEY_DEPTH > 1) ? $clog2(KEY_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(KEY_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] key_slice(input logic [TOTAL_BITS-1:0] sample);
        return sample[KEY_LSB +: 8];
    endfunction

    function automatic logic [7:0] key_byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            2'd3:    b = word[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    state_t          state_r;
    logic [31:0]     key_mem_r [KEY_DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   key_cnt_r;
    logic [1:0]      byte_idx_r;
    logic [7:0]      prev_c_r;
    logic [15:0]     pix_cnt_r;
    logic [15:0]     len_r;
    logic [7:0]      m_data_r;
    logic            m_valid_r;
    logic            m_last_r;
    logic            done_r;

    logic            all_valid_s;
    logic            push_s;
    logic            pop_s;
    logic            s_ready_s;
    logic            accept_s;
    logic [31:0]     key_word_s;
    logic [7:0]      key_byte_s;
    logic [7:0]      cipher_s;
    logic [15:0]     pix_next_s;
    logic            last_s;
    logic            out_done_s;
    logic            frame_go_s;
    logic            unused_bits_s;

    // Only the key slice of each sample is consumed; fold the rest so every input bit has a sink.
    assign unused_bits_s = ^{x_seq, y_seq, z_seq, w_seq};

    assign all_valid_s = x_ap_valid & y_ap_valid & z_ap_valid & w_ap_valid;
    assign push_s      = all_valid_s & (key_cnt_r < DEPTH_C);
    assign s_ready_s   = (state_r == ST_RUN) & (key_cnt_r != {CW{1'b0}}) & (~m_valid_r | m_ready);
    assign accept_s    = s_valid & s_ready_s;
    assign key_word_s  = key_mem_r[rd_ptr_r];
    assign key_byte_s  = key_byte_sel(key_word_s, byte_idx_r);
    assign cipher_s    = s_data ^ key_byte_s ^ prev_c_r;
    assign pix_next_s  = pix_cnt_r + 16'd1;
    assign last_s      = (pix_next_s == len_r);
    // The final pixel of a frame retires the head word even when only partly used.
    assign pop_s       = accept_s & ((byte_idx_r == 2'd3) | last_s);
    assign out_done_s  = ~m_valid_r | (m_valid_r & m_ready & m_last_r);
    assign frame_go_s  = (state_r == ST_IDLE) & frame_start;

    assign chaos_start = (key_cnt_r < DEPTH_C);
    assign s_ready     = s_ready_s;
    assign m_data      = m_data_r;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign busy        = (state_r != ST_IDLE);
    assign done        = done_r;

    // Key FIFO storage and write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                key_mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            key_mem_r[wr_ptr_r] <= {key_slice(x_seq), key_slice(y_seq),
                                    key_slice(z_seq), key_slice(w_seq)};
            wr_ptr_r            <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Key FIFO read pointer, occupancy and byte cursor within the head word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r   <= {AW{1'b0}};
            key_cnt_r  <= {CW{1'b0}};
            byte_idx_r <= 2'd0;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   key_cnt_r <= key_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   key_cnt_r <= key_cnt_r - {{(CW-1){1'b0}}, 1'b1};
                default: key_cnt_r <= key_cnt_r;
            endcase
            if (pop_s) begin
                byte_idx_r <= 2'd0;
            end else if (accept_s) begin
                byte_idx_r <= byte_idx_r + 2'd1;
            end else begin
                byte_idx_r <= byte_idx_r;
            end
        end
    end

    // Frame bookkeeping: chaining value, pixel count and latched length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_c_r  <= IV;
            pix_cnt_r <= 16'd0;
            len_r     <= 16'd0;
        end else if (frame_go_s) begin
            prev_c_r  <= IV;
            pix_cnt_r <= 16'd0;
            len_r     <= cfg_len;
        end else if (accept_s) begin
            prev_c_r  <= cipher_s;
            pix_cnt_r <= pix_next_s;
            len_r     <= len_r;
        end else begin
            prev_c_r  <= prev_c_r;
            pix_cnt_r <= pix_cnt_r;
            len_r     <= len_r;
        end
    end

    // Cipher output register; held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r  <= 8'h00;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (accept_s) begin
            m_data_r  <= cipher_s;
            m_valid_r <= 1'b1;
            m_last_r  <= last_s;
        end else if (m_ready) begin
            m_data_r  <= m_data_r;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else begin
            m_data_r  <= m_data_r;
            m_valid_r <= m_valid_r;
            m_last_r  <= m_last_r;
        end
    end

    // Frame control FSM with the registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_r <= (cfg_len == 16'd0) ? ST_DONE : ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (accept_s && last_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_done_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chaos_keystream_xor.sv
// Self-checking bench for chaos_keystream_xor: queue-based reference model checked every cycle,
// plus directed frames with hand-computed cipher bytes.
module tb_chaos_keystream_xor;

    logic        clk;
    logic        rst_n;
    logic        chaos_start;
    logic [31:0] x_seq, y_seq, z_seq, w_seq;
    logic        x_ap_valid, y_ap_valid, z_ap_valid, w_ap_valid;
    logic        frame_start;
    logic [15:0] cfg_len;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int done_cyc = 0;

    logic [31:0] kq[$];
    logic [8:0]  expq[$];
    logic [8:0]  obs[$];
    logic [7:0]  pix_q[$];
    int          kbyte = 0;
    int          left = 0;
    logic [7:0]  prev = 8'h5A;

    chaos_keystream_xor dut (
        .clk(clk), .rst_n(rst_n), .chaos_start(chaos_start),
        .x_seq(x_seq), .y_seq(y_seq), .z_seq(z_seq), .w_seq(w_seq),
        .x_ap_valid(x_ap_valid), .y_ap_valid(y_ap_valid),
        .z_ap_valid(z_ap_valid), .w_ap_valid(w_ap_valid),
        .frame_start(frame_start), .cfg_len(cfg_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chaos(input logic [31:0] x, input logic [31:0] y,
                             input logic [31:0] z, input logic [31:0] w, input logic v);
        x_seq = x; y_seq = y; z_seq = z; w_seq = w;
        x_ap_valid = v; y_ap_valid = v; z_ap_valid = v; w_ap_valid = v;
    endtask

    task automatic start_frame(input logic [15:0] len);
        cfg_len = len;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic feed_all(input string nm);
        logic acc;
        for (int i = 0; i < 200 && pix_q.size() > 0; i++) begin
            s_valid = 1'b1;
            s_data = pix_q[0];
            @(negedge clk);
            acc = s_ready;
            step();
            if (acc) void'(pix_q.pop_front());
        end
        s_valid = 1'b0;
        chk(nm, pix_q.size(), 0);
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        chk(nm, seen, 1'b1);
        step();
    endtask

    // Reference model: key words as a queue of packed slices, one pending output byte at most.
    initial begin : monitor
        logic [31:0] w;
        logic [7:0]  kb, c;
        logic        push_ok, lst, exp_rdy;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                kq.delete();
                expq.delete();
                kbyte = 0;
                left = 0;
                prev = 8'h5A;
            end else begin
                chk("chaos_start", chaos_start, kq.size() < 4);
                exp_rdy = (left != 0) && (kq.size() != 0) && ((expq.size() == 0) || m_ready);
                chk("s_ready", s_ready, exp_rdy);
                chk("m_valid", m_valid, expq.size() != 0);
                if (expq.size() != 0) begin
                    chk("m_data", m_data, expq[0][7:0]);
                    chk("m_last", m_last, expq[0][8]);
                end
                if (m_valid && m_ready) begin
                    obs.push_back({m_last, m_data});
                    if (m_last) last_cyc = cyc;
                    if (expq.size() != 0) void'(expq.pop_front());
                end
                if (done) done_cyc = cyc;
                push_ok = x_ap_valid && y_ap_valid && z_ap_valid && w_ap_valid && (kq.size() < 4);
                if (s_valid && s_ready && kq.size() != 0 && left != 0) begin
                    w = kq[0];
                    kb = 8'(w >> (8 * (3 - kbyte)));
                    c = s_data ^ kb ^ prev;
                    prev = c;
                    left--;
                    lst = (left == 0);
                    expq.push_back({lst, c});
                    kbyte++;
                    if (kbyte == 4 || lst) begin
                        void'(kq.pop_front());
                        kbyte = 0;
                    end
                end
                if (frame_start && left == 0) begin
                    prev = 8'h5A;
                    left = int'(cfg_len);
                end
                if (push_ok) kq.push_back({x_seq[23:16], y_seq[23:16], z_seq[23:16], w_seq[23:16]});
            end
        end
    end

    initial begin : stim
        logic seen_v;
        rst_n = 1'b0;
        set_chaos(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        frame_start = 1'b0; cfg_len = 16'd0;
        s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
        #3;
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_chaos_start", chaos_start, 1'b1);
        step();
        rst_n = 1'b1;
        step();

        // Fill the key FIFO with no frame running; it must stop at depth 4.
        set_chaos(32'h0011_0000, 32'h0022_0000, 32'h0033_0000, 32'h0044_0000, 1'b1);
        repeat (6) step();
        chk("fill_chaos_start", chaos_start, 1'b0);
        set_chaos(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        // Frame of four zero pixels.
        obs.delete();
        start_frame(16'd4);
        pix_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        feed_all("t1_feed");
        wait_done("t1_done");
        chk("t1_count", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t1_b0", obs[0], 9'h04B);
            chk("t1_b1", obs[1], 9'h069);
            chk("t1_b2", obs[2], 9'h05A);
            chk("t1_b3", obs[3], 9'h11E);
        end
        chk("t1_done_lat", done_cyc - last_cyc, 1);

        // Same frame with the consumer stalled for five cycles after the first byte.
        obs.delete();
        start_frame(16'd4);
        pix_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        fork
            feed_all("t2_feed");
            begin
                seen_v = 1'b0;
                for (int i = 0; i < 20 && !seen_v; i++) begin
                    @(posedge clk);
                    #1;
                    seen_v = m_valid;
                end
                chk("t2_first_out", seen_v, 1'b1);
                m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t2_hold_data", m_data, 8'h4B);
                    chk("t2_hold_valid", m_valid, 1'b1);
                    chk("t2_hold_sready", s_ready, 1'b0);
                    step();
                end
                m_ready = 1'b1;
            end
        join
        wait_done("t2_done");
        chk("t2_count", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t2_b0", obs[0], 9'h04B);
            chk("t2_b3", obs[3], 9'h11E);
        end

        // Drain the remaining two words, then starve the frame of keys.
        start_frame(16'd8);
        pix_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        feed_all("t3a_feed");
        wait_done("t3a_done");
        obs.delete();
        start_frame(16'd1);
        s_valid = 1'b1;
        s_data = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_starved_sready", s_ready, 1'b0);
            step();
        end
        set_chaos(32'h00AB_0000, 32'h00CD_0000, 32'h00EF_0000, 32'h0012_0000, 1'b1);
        step();
        set_chaos(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t3_key_sready", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
        wait_done("t3_done");
        chk("t3_count", obs.size(), 1);
        if (obs.size() == 1) chk("t3_b0", obs[0], 9'h1FE);

        // Partial word discard across frames.
        set_chaos(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1);
        step();
        set_chaos(32'h0005_0000, 32'h0006_0000, 32'h0007_0000, 32'h0008_0000, 1'b1);
        step();
        set_chaos(32'h0009_0000, 32'h000A_0000, 32'h000B_0000, 32'h000C_0000, 1'b1);
        step();
        set_chaos(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        obs.delete();
        start_frame(16'd6);
        pix_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        feed_all("t4a_feed");
        wait_done("t4a_done");
        start_frame(16'd1);
        pix_q = '{8'h00};
        feed_all("t4b_feed");
        wait_done("t4b_done");
        chk("t4_count", obs.size(), 7);
        if (obs.size() == 7) begin
            chk("t4_b0", obs[0], 9'h05B);
            chk("t4_b3", obs[3], 9'h05E);
            chk("t4_b5", obs[5], 9'h15D);
            chk("t4_f2", obs[6], 9'h153);
        end

        // Zero-length frame.
        start_frame(16'd0);
        @(negedge clk);
        chk("t5_done_early", done, 1'b0);
        chk("t5_busy", busy, 1'b1);
        step();
        @(negedge clk);
        chk("t5_done", done, 1'b1);
        chk("t5_busy_end", busy, 1'b0);
        chk("t5_no_valid", m_valid, 1'b0);
        step();
        @(negedge clk);
        chk("t5_done_pulse", done, 1'b0);
        step();

        // Reset in the middle of a stalled frame.
        set_chaos(32'h0077_0000, 32'h0066_0000, 32'h0055_0000, 32'h0044_0000, 1'b1);
        repeat (5) step();
        set_chaos(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("t6_full", chaos_start, 1'b0);
        m_ready = 1'b0;
        start_frame(16'd10);
        s_valid = 1'b1;
        s_data = 8'h33;
        step();
        chk("t6_pending", m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_valid", m_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_chaos_start", chaos_start, 1'b1);
        chk("t6_rst_m_last", m_last, 1'b0);
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("t6_post_sready", s_ready, 1'b0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
